// File: rtl/axil_master_port.sv
// AXI4-Lite master port: single-beat local write/read commands onto AW/W/B and AR/R.
// Define AXIL_TIMEOUT_EN to add a per-path response timeout with silent late-response drain.
module axil_master_port #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int STRB_W      = DATA_W/8,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              aCLK,
  input  logic              ARESETn,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  output logic              wr_done,
  output logic [1:0]        wr_resp,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axil_master_port: DATA_W must be 32 or 64");
  end
  if (STRB_W != DATA_W/8) begin : g_bad_strb_w
    $error("axil_master_port: STRB_W must equal DATA_W/8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("axil_master_port: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic              aw_ok, w_ok, aw_ok_nxt, w_ok_nxt;
  logic              awvalid_nxt, wvalid_nxt, bready_nxt, wr_ready_nxt, wr_done_nxt;
  logic [ADDR_W-1:0] awaddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [STRB_W-1:0] wstrb_nxt;
  logic [1:0]        wr_resp_nxt;

  logic              arvalid_nxt, rready_nxt, rd_ready_nxt, rd_done_nxt;
  logic [ADDR_W-1:0] araddr_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic [1:0]        rd_resp_nxt;

  logic              w_timeout, r_timeout;

`ifdef AXIL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] w_cnt, r_cnt;
  logic            w_drain, w_drain_nxt, r_drain, r_drain_nxt;

  // Counters only run while waiting for a response; address/data VALIDs are never timed out.
  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      w_cnt   <= '0;
      r_cnt   <= '0;
      w_drain <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      w_cnt   <= (w_state == W_RESP && !BVALID) ? w_cnt + TO_W'(1) : '0;
      r_cnt   <= (r_state == R_DATA && !RVALID) ? r_cnt + TO_W'(1) : '0;
      w_drain <= w_drain_nxt;
      r_drain <= r_drain_nxt;
    end
  end

  assign w_timeout = (w_state == W_RESP) && !BVALID && (w_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign r_timeout = (r_state == R_DATA) && !RVALID && (r_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
  assign r_timeout = 1'b0;
`endif

  // AW and W complete independently; each flag remembers its own handshake.
  assign aw_ok_nxt = (w_state == W_SEND) && (aw_ok || (AWVALID && AWREADY));
  assign w_ok_nxt  = (w_state == W_SEND) && (w_ok  || (WVALID  && WREADY));

  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      w_state  <= W_IDLE;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      AWADDR   <= '0;
      AWVALID  <= 1'b0;
      WDATA    <= '0;
      WSTRB    <= '0;
      WVALID   <= 1'b0;
      BREADY   <= 1'b0;
      wr_ready <= 1'b1;
      wr_done  <= 1'b0;
      wr_resp  <= 2'b00;
      r_state  <= R_IDLE;
      ARADDR   <= '0;
      ARVALID  <= 1'b0;
      RREADY   <= 1'b0;
      rd_ready <= 1'b1;
      rd_done  <= 1'b0;
      rd_data  <= '0;
      rd_resp  <= 2'b00;
    end else begin
      w_state  <= w_state_nxt;
      aw_ok    <= aw_ok_nxt;
      w_ok     <= w_ok_nxt;
      AWADDR   <= awaddr_nxt;
      AWVALID  <= awvalid_nxt;
      WDATA    <= wdata_nxt;
      WSTRB    <= wstrb_nxt;
      WVALID   <= wvalid_nxt;
      BREADY   <= bready_nxt;
      wr_ready <= wr_ready_nxt;
      wr_done  <= wr_done_nxt;
      wr_resp  <= wr_resp_nxt;
      r_state  <= r_state_nxt;
      ARADDR   <= araddr_nxt;
      ARVALID  <= arvalid_nxt;
      RREADY   <= rready_nxt;
      rd_ready <= rd_ready_nxt;
      rd_done  <= rd_done_nxt;
      rd_data  <= rd_data_nxt;
      rd_resp  <= rd_resp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_req && wr_ready) w_state_nxt = W_SEND;
      W_SEND:  if (aw_ok_nxt && w_ok_nxt) w_state_nxt = W_RESP;
      W_RESP:  if (BVALID || w_timeout) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Output values are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    awaddr_nxt   = AWADDR;
    wdata_nxt    = WDATA;
    wstrb_nxt    = WSTRB;
    awvalid_nxt  = 1'b0;
    wvalid_nxt   = 1'b0;
    bready_nxt   = 1'b0;
    wr_ready_nxt = 1'b0;
    wr_done_nxt  = 1'b0;
    wr_resp_nxt  = wr_resp;
`ifdef AXIL_TIMEOUT_EN
    w_drain_nxt  = w_drain;
`endif
    case (w_state)
      W_IDLE: begin
        wr_ready_nxt = 1'b1;
`ifdef AXIL_TIMEOUT_EN
        if (w_drain) begin
          wr_ready_nxt = 1'b0;
          bready_nxt   = 1'b1;
          if (BVALID) begin
            w_drain_nxt  = 1'b0;
            bready_nxt   = 1'b0;
            wr_ready_nxt = 1'b1;
          end
        end
`endif
        if (wr_req && wr_ready) begin
          awaddr_nxt   = wr_addr;
          wdata_nxt    = wr_data;
          wstrb_nxt    = wr_strb;
          awvalid_nxt  = 1'b1;
          wvalid_nxt   = 1'b1;
          wr_ready_nxt = 1'b0;
        end
      end
      W_SEND: begin
        awvalid_nxt = AWVALID && !AWREADY;
        wvalid_nxt  = WVALID && !WREADY;
        bready_nxt  = aw_ok_nxt && w_ok_nxt;
      end
      W_RESP: begin
        bready_nxt = 1'b1;
        if (BVALID) begin
          bready_nxt   = 1'b0;
          wr_done_nxt  = 1'b1;
          wr_resp_nxt  = BRESP;
          wr_ready_nxt = 1'b1;
        end else if (w_timeout) begin
          wr_done_nxt = 1'b1;
          wr_resp_nxt = 2'b11;
`ifdef AXIL_TIMEOUT_EN
          w_drain_nxt = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (rd_req && rd_ready) r_state_nxt = R_ADDR;
      R_ADDR:  if (ARREADY) r_state_nxt = R_DATA;
      R_DATA:  if (RVALID || r_timeout) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    araddr_nxt   = ARADDR;
    arvalid_nxt  = 1'b0;
    rready_nxt   = 1'b0;
    rd_ready_nxt = 1'b0;
    rd_done_nxt  = 1'b0;
    rd_data_nxt  = rd_data;
    rd_resp_nxt  = rd_resp;
`ifdef AXIL_TIMEOUT_EN
    r_drain_nxt  = r_drain;
`endif
    case (r_state)
      R_IDLE: begin
        rd_ready_nxt = 1'b1;
`ifdef AXIL_TIMEOUT_EN
        if (r_drain) begin
          rd_ready_nxt = 1'b0;
          rready_nxt   = 1'b1;
          if (RVALID) begin
            r_drain_nxt  = 1'b0;
            rready_nxt   = 1'b0;
            rd_ready_nxt = 1'b1;
          end
        end
`endif
        if (rd_req && rd_ready) begin
          araddr_nxt   = rd_addr;
          arvalid_nxt  = 1'b1;
          rd_ready_nxt = 1'b0;
        end
      end
      R_ADDR: begin
        arvalid_nxt = !ARREADY;
        rready_nxt  = ARREADY;
      end
      R_DATA: begin
        rready_nxt = 1'b1;
        if (RVALID) begin
          rready_nxt   = 1'b0;
          rd_done_nxt  = 1'b1;
          rd_data_nxt  = RDATA;
          rd_resp_nxt  = RRESP;
          rd_ready_nxt = 1'b1;
        end else if (r_timeout) begin
          rd_done_nxt = 1'b1;
          rd_resp_nxt = 2'b11;
          rd_data_nxt = '0;
`ifdef AXIL_TIMEOUT_EN
          r_drain_nxt = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_master_port.sv
// Self-checking bench for axil_master_port: configurable-latency AXI-Lite slave plus response scoreboard.
module tb_axil_master_port;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W/8;

  logic              aCLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              wr_req = 1'b0, wr_ready, wr_done;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [STRB_W-1:0] wr_strb = '0;
  logic [1:0]        wr_resp;
  logic              rd_req = 1'b0, rd_ready, rd_done;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic [STRB_W-1:0] WSTRB;
  logic [1:0]        BRESP, RRESP;

  axil_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(8)) dut (
    .aCLK(aCLK), .ARESETn(ARESETn),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_data(rd_data), .rd_resp(rd_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 aCLK = ~aCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Slave knobs: READY/VALID asserted after the given number of wait cycles.
  int                aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int                aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit                b_block = 1'b0;
  logic [1:0]        b_resp_v = 2'b00, r_resp_v = 2'b00;
  logic [DATA_W-1:0] r_data_v = '0;

  // Scoreboard state
  logic [ADDR_W-1:0] exp_awaddr = '0, exp_araddr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  logic [STRB_W-1:0] exp_wstrb = '0;
  logic [1:0]        wr_exp_q[$];
  logic [DATA_W+1:0] rd_exp_q[$];

  task automatic tick();
    @(posedge aCLK);
    #1;
  endtask

  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
    forever begin
      tick();
      AWREADY = AWVALID && (aw_cnt >= aw_lat);
      aw_cnt  = AWVALID ? aw_cnt + 1 : 0;
      WREADY  = WVALID && (w_cnt >= w_lat);
      w_cnt   = WVALID ? w_cnt + 1 : 0;
      BVALID  = BREADY && !b_block && (b_cnt >= b_lat);
      b_cnt   = BREADY ? b_cnt + 1 : 0;
      BRESP   = BVALID ? b_resp_v : 2'b00;
      ARREADY = ARVALID && (ar_cnt >= ar_lat);
      ar_cnt  = ARVALID ? ar_cnt + 1 : 0;
      RVALID  = RREADY && (r_cnt >= r_lat);
      r_cnt   = RREADY ? r_cnt + 1 : 0;
      RDATA   = RVALID ? r_data_v : 32'hBAD0_BAD0;
      RRESP   = RVALID ? r_resp_v : 2'b00;
    end
  end

  always @(negedge aCLK) begin
    if (ARESETn) begin
      if (AWVALID) chk("awaddr_stable", AWADDR, exp_awaddr);
      if (WVALID) begin
        chk("wdata_stable", WDATA, exp_wdata);
        chk("wstrb_stable", WSTRB, exp_wstrb);
      end
      if (ARVALID) chk("araddr_stable", ARADDR, exp_araddr);
      if (wr_done) begin
        if (wr_exp_q.size() == 0) chk("wr_done_unexpected", wr_done, 0);
        else chk("wr_resp", wr_resp, wr_exp_q.pop_front());
      end
      if (rd_done) begin
        if (rd_exp_q.size() == 0) chk("rd_done_unexpected", rd_done, 0);
        else chk("rd_resp_data", {rd_resp, rd_data}, rd_exp_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input logic [1:0] resp, input bit expect_done);
    exp_awaddr = a; exp_wdata = d; exp_wstrb = s;
    if (expect_done) wr_exp_q.push_back(resp);
    wr_addr = a; wr_data = d; wr_strb = s; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [1:0] resp,
                         input logic [DATA_W-1:0] d);
    exp_araddr = a;
    rd_exp_q.push_back({resp, d});
    rd_addr = a; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_wr_done(input int max, output int n);
    n = 0;
    while (!wr_done && n < max) begin tick(); n++; end
    if (!wr_done) chk("wr_done_wait", wr_done, 1);
  endtask

  task automatic wait_rd_done(input int max, output int n);
    n = 0;
    while (!rd_done && n < max) begin tick(); n++; end
    if (!rd_done) chk("rd_done_wait", rd_done, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_awvalid"}, AWVALID, 0);
    chk({tag, "_wvalid"},  WVALID, 0);
    chk({tag, "_bready"},  BREADY, 0);
    chk({tag, "_arvalid"}, ARVALID, 0);
    chk({tag, "_rready"},  RREADY, 0);
    chk({tag, "_payload"}, {AWADDR, WDATA, WSTRB, ARADDR}, 0);
    chk({tag, "_dones"},   {wr_done, rd_done}, 0);
    chk({tag, "_resps"},   {wr_resp, rd_resp, rd_data}, 0);
    chk({tag, "_readys"},  {wr_ready, rd_ready}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, wd, rdn;
    repeat (3) tick();
    check_reset_vals("rst_init");
    ARESETn = 1'b1;
    tick();

    // Zero-wait write
    do_write(11'h005, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1);
    chk("t1_valids_c1", {AWVALID, WVALID, wr_ready}, 3'b110);
    chk("t1_payload_c1", {AWADDR, WDATA, WSTRB}, {11'h005, 32'hDEAD_BEEF, 4'hF});
    tick();
    chk("t1_c2", {AWVALID, WVALID, BREADY, wr_done}, 4'b0010);
    tick();
    chk("t1_done_c3", {wr_done, wr_ready, BREADY}, 3'b110);
    tick();
    chk("t1_done_pulse", wr_done, 0);

    // AWREADY delayed 4 cycles, WREADY immediate
    aw_lat = 4;
    do_write(11'h2F0, 32'h0123_4567, 4'h5, 2'b00, 1'b1);
    chk("t2_c1", {AWVALID, WVALID}, 2'b11);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("t2_aw_hold", {AWVALID, WVALID, BREADY}, 3'b100);
    end
    tick();
    chk("t2_aw_drop", {AWVALID, BREADY}, 2'b01);
    wait_wr_done(10, n);
    chk("t2_lat", n, 1);
    tick();
    aw_lat = 0;

    // Read with 3 response wait cycles and SLVERR
    r_lat = 3; r_data_v = 32'h1234_5678; r_resp_v = 2'b10;
    do_read(11'h40A, 2'b10, 32'h1234_5678);
    chk("t3_ar_c1", {ARVALID, ARADDR, rd_ready}, {1'b1, 11'h40A, 1'b0});
    wait_rd_done(20, n);
    chk("t3_lat", n, 5);
    chk("t3_data", {rd_data, rd_resp}, {32'h1234_5678, 2'b10});
    tick();
    chk("t3_after", {rd_done, rd_ready, RREADY}, 3'b010);

    // Concurrent write and read; second wr_req while busy is ignored
    aw_lat = 1; w_lat = 2; b_lat = 1; b_resp_v = 2'b01;
    r_lat = 2; r_data_v = 32'hCAFE_F00D; r_resp_v = 2'b00;
    exp_awaddr = 11'h123; exp_wdata = 32'hA5A5_5A5A; exp_wstrb = 4'h3;
    exp_araddr = 11'h7FF;
    wr_exp_q.push_back(2'b01);
    rd_exp_q.push_back({2'b00, 32'hCAFE_F00D});
    wr_addr = 11'h123; wr_data = 32'hA5A5_5A5A; wr_strb = 4'h3; wr_req = 1'b1;
    rd_addr = 11'h7FF; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t4_both_active", {AWVALID, WVALID, ARVALID, wr_ready, rd_ready}, 5'b11100);
    wr_addr = 11'h0AA; wr_data = 32'h1111_1111; wr_strb = 4'hC;
    tick();
    wr_req = 1'b0;
    wd = 0; rdn = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (wr_done) wd++;
      if (rd_done) rdn++;
    end
    chk("t4_wr_done_count", wd, 1);
    chk("t4_rd_done_count", rdn, 1);
    aw_lat = 0; w_lat = 0; b_lat = 0; b_resp_v = 2'b00; r_lat = 0;

    // Reset while AWVALID is high
    aw_lat = 10;
    do_write(11'h3C3, 32'h5555_AAAA, 4'h9, 2'b00, 1'b0);
    chk("t5_aw_c1", AWVALID, 1);
    tick();
    ARESETn = 1'b0;
    tick();
    check_reset_vals("t5_rst");
    ARESETn = 1'b1;
    repeat (12) tick();
    chk("t5_idle", {wr_ready, AWVALID, BREADY}, 3'b100);
    aw_lat = 0;
    do_write(11'h011, 32'h7777_8888, 4'hF, 2'b00, 1'b1);
    wait_wr_done(10, n);
    chk("t5_recover_lat", n, 2);
    tick();

`ifdef AXIL_TIMEOUT_EN
    // BVALID withheld: timeout response, then late BVALID drained silently
    b_block = 1'b1;
    do_write(11'h055, 32'h0BAD_F00D, 4'hF, 2'b11, 1'b1);
    tick();
    chk("t6_bready", BREADY, 1);
    wait_wr_done(20, n);
    chk("t6_timeout_lat", n, 8);
    chk("t6_state", {wr_resp, wr_ready, BREADY}, 4'b1101);
    repeat (3) tick();
    chk("t6_drain_hold", {wr_ready, BREADY}, 2'b01);
    b_block = 1'b0;
    n = 0;
    while (!wr_ready && n < 10) begin tick(); n++; end
    chk("t6_drain_done", {wr_ready, BREADY, wr_done}, 3'b100);
    repeat (3) tick();
`endif

    chk("wr_queue_empty", wr_exp_q.size(), 0);
    chk("rd_queue_empty", rd_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master_port.md
Name: axil_master_port

Overview:
- Parametrised AXI4-Lite master port; next generation of the per-channel TX/RX handshake FSMs.
- Turns single-beat local write/read commands into AXI-Lite transactions. Returns the response to the local side.
- Write path (AW/W/B) and read path (AR/R) are independent and may run concurrently.
- Adds WSTRB, independent AW/W completion, registered response capture and done pulses.

Parameters:
ADDR_W, 11, address width (MSB selects slave)
DATA_W, 32, data width; must be 32 or 64
STRB_W, DATA_W/8, write-strobe width (derived; not overridden)
TIMEOUT_CYC, 256, response timeout in cycles (used only with AXIL_TIMEOUT_EN)

Ports:
aCLK  in  1  clock
ARESETn  in  1  reset
wr_req  in  1  local write request
wr_ready  out  1  write path idle; request accepted when wr_req&&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_strb  in  STRB_W  byte enables
wr_done  out  1  one-cycle pulse on write completion
wr_resp  out  2  BRESP captured (valid with wr_done, held after)
rd_req  in  1  local read request
rd_ready  out  1  read path idle
rd_addr  in  ADDR_W  read address
rd_done  out  1  one-cycle pulse on read completion
rd_data  out  DATA_W  captured RDATA
rd_resp  out  2  captured RRESP
AWADDR/AWVALID/AWREADY  out/out/in  ADDR_W/1/1  AW channel
WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DATA_W/STRB_W/1/1  W channel
BRESP/BVALID/BREADY  in/in/out  2/1/1  B channel
ARADDR/ARVALID/ARREADY  out/out/in  ADDR_W/1/1  AR channel
RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_W/2/1/1  R channel

Behaviour:
- Interface: reset ARESETn, synchronous, active-low; clock aCLK.
- All outputs registered.
- Reset values:
  - all VALID/READY = 0; AWADDR/WDATA/WSTRB/ARADDR = 0; wr_done/rd_done = 0.
  - wr_resp/rd_resp/rd_data = 0; wr_ready/rd_ready = 1.
- Write FSM W_IDLE -> W_SEND -> W_RESP -> W_IDLE:
  - W_IDLE: on wr_req, latch addr/data/strb; next cycle AWVALID=WVALID=1, wr_ready=0.
  - W_SEND: AWVALID drops the cycle after AWREADY is sampled high. WVALID likewise with WREADY. aw_ok/w_ok flags track each. Both handshakes in one cycle is legal. Go to W_RESP when both flags are set (including same cycle). VALID is never withdrawn before its handshake; payload is stable while VALID=1.
  - W_RESP: BREADY=1. On BVALID: capture BRESP into wr_resp, pulse wr_done. Next cycle: BREADY=0, state W_IDLE, wr_ready=1.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: on rd_req, latch rd_addr.
  - R_ADDR: ARVALID=1 until ARREADY.
  - R_DATA: RREADY=1. On RVALID: capture RDATA/RRESP, pulse rd_done, return to R_IDLE.
- Latency with zero-wait slave (READY always 1, response the cycle after the address):
  - wr_req accepted at cycle 0 -> VALIDs at cycle 1 -> wr_done at cycle 3.
  - Read: rd_done at cycle 3.
- Requests arriving while the respective ready=0 are ignored (not queued).
- wr_req and rd_req in the same cycle: both accepted.
- Reset mid-transaction: FSMs to IDLE, all outputs to reset values next edge, no done pulse.
- BRESP/RRESP are passed through unchanged; SLVERR/DECERR do not alter FSM flow.

Optional Feature:
- Macro AXIL_TIMEOUT_EN.
- Defined:
  - A per-path counter runs in W_RESP and R_DATA.
  - Reaching TIMEOUT_CYC without handshake: pulse done with resp=2'b11, rd_data=0, return to IDLE.
  - A drain flag then holds BREADY/RREADY=1 until the late response is consumed silently. ready stays 0 until the drain completes.
  - Counter is not active in W_SEND/R_ADDR (VALID must not drop).
- Undefined: no counter; path waits for the response indefinitely.

Test Plan:
- Zero-wait slave, write addr=0x005 data=0xDEADBEEF strb=0xF -> AWADDR=0x005, WDATA=0xDEADBEEF, WSTRB=0xF on cycle 1; wr_done at cycle 3, wr_resp=00.
- AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops after cycle 1, AWVALID held 5 cycles with stable AWADDR, BREADY asserted only after AW handshake.
- Read addr=0x40A, slave returns RDATA=0x12345678 RRESP=10 after 3 wait cycles -> rd_done single pulse, rd_data=0x12345678, rd_resp=10, rd_ready=1 next cycle.
- Simultaneous wr_req and rd_req -> both channel sets active concurrently, both done pulses, no cross-corruption; second wr_req while wr_ready=0 ignored.
- ARESETn low for 1 cycle while AWVALID=1 -> next edge all VALID/READY=0, no wr_done, wr_ready=1.
- With AXIL_TIMEOUT_EN, TIMEOUT_CYC=8, BVALID withheld -> wr_done with wr_resp=11 at 8 cycles; later BVALID consumed with no extra wr_done.
